// File: rtl/muldiv_sequencer.sv
// Iterative 16x16 shift-add multiplier / restoring divider: 16 CALC cycles, divide-by-zero short-cuts to DONE.
// Define MULDIV_SIGNED_EN for two's-complement operands (magnitude datapath plus sign fix-up on the result).
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div0,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        op_q;
  logic [15:0] opnd;
  logic [15:0] hi;
  logic [15:0] lo;

  logic [16:0] add_sum;
  logic [16:0] shifted;
  logic [16:0] sub_diff;
  logic [15:0] hi_nx;
  logic [15:0] lo_nx;
  logic [31:0] fin;
  logic [15:0] a_m;
  logic [15:0] b_m;

`ifdef MULDIV_SIGNED_EN
  logic neg_p;
  logic neg_r;

  assign a_m = a[15] ? 16'(-a) : a;
  assign b_m = b[15] ? 16'(-b) : b;
`else
  assign a_m = a;
  assign b_m = b;
`endif

  // hi/lo hold {acc, multiplier} for multiply and {remainder, quotient} for divide,
  // so the final step already has the result layout for both operations.
  always_comb begin
    add_sum  = {1'b0, hi} + {1'b0, opnd};
    shifted  = {hi, lo[15]};
    sub_diff = shifted - {1'b0, opnd};
    hi_nx    = hi;
    lo_nx    = lo;
    if (!op_q) begin
      if (lo[0]) {hi_nx, lo_nx} = {add_sum, lo[15:1]};
      else       {hi_nx, lo_nx} = {1'b0, hi, lo[15:1]};
    end else begin
      // sub_diff[16] is the borrow: set only when the shifted remainder is below the divisor
      if (!sub_diff[16]) begin
        hi_nx = sub_diff[15:0];
        lo_nx = {lo[14:0], 1'b1};
      end else begin
        hi_nx = shifted[15:0];
        lo_nx = {lo[14:0], 1'b0};
      end
    end
`ifdef MULDIV_SIGNED_EN
    if (op_q) fin = {(neg_r ? 16'(-hi_nx) : hi_nx), (neg_p ? 16'(-lo_nx) : lo_nx)};
    else      fin = neg_p ? 32'(-{hi_nx, lo_nx}) : {hi_nx, lo_nx};
`else
    fin = {hi_nx, lo_nx};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      op_q   <= 1'b0;
      opnd   <= 16'h0;
      hi     <= 16'h0;
      lo     <= 16'h0;
      div0   <= 1'b0;
      result <= 32'h0;
`ifdef MULDIV_SIGNED_EN
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else if (!halt_sys) begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            opnd <= op ? b_m : a_m;
            lo   <= op ? a_m : b_m;
            hi   <= 16'h0;
            cnt  <= 4'd0;
`ifdef MULDIV_SIGNED_EN
            neg_p <= a[15] ^ b[15];
            neg_r <= a[15];
`endif
            if (op && (b == 16'h0)) begin
              state  <= DONE;
              div0   <= 1'b1;
              result <= {a, 16'hFFFF};
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state  <= DONE;
            div0   <= 1'b0;
            result <= fin;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign stall = !halt_sys && (((state == IDLE) && start) || (state == CALC));
  assign done  = !halt_sys && (state == DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + random bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        halt_sys;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div0;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .stall(stall), .done(done), .div0(div0), .result(result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {div0, result} straight from the arithmetic definition.
  function automatic logic [32:0] model(input logic [15:0] ta, input logic [15:0] tb_, input logic top);
    if (top && tb_ == 16'h0) return {1'b1, ta, 16'hFFFF};
`ifdef MULDIV_SIGNED_EN
    begin
      int sa, sb, p, q, r;
      sa = int'($signed(ta));
      sb = int'($signed(tb_));
      if (!top) begin
        p = sa * sb;
        return {1'b0, 32'(p)};
      end
      q = sa / sb;
      r = sa % sb;
      return {1'b0, 16'(r), 16'(q)};
    end
`else
    begin
      logic [31:0] pa;
      if (!top) begin
        pa = {16'h0, ta} * {16'h0, tb_};
        return {1'b0, pa};
      end
      return {1'b0, 16'(ta % tb_), 16'(ta / tb_)};
    end
`endif
  endfunction

  // One operation; optional start re-injection and halt window, indexed by negedges after the sampling edge.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_, input logic top,
                        input int inject_at, input int halt_at, input int halt_len);
    logic [32:0] exp;
    logic [31:0] got_res;
    logic        got_div0;
    int          lat;
    int          stalls;
    bit          seen;
    exp = model(ta, tb_, top);
    @(negedge clk);
    a = ta; b = tb_; op = top; start = 1'b1;
    #1 check({tag, " stall_req"}, 32'(stall), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    stalls = 1; seen = 0; lat = 0; got_res = '0; got_div0 = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin
        seen = 1; lat = k; got_res = result; got_div0 = div0;
      end
      if (halt_len > 0 && k == halt_at + 1) begin
        check({tag, " halt_stall"}, 32'(stall), 32'd0);
        check({tag, " halt_busy"}, 32'(busy), 32'd1);
      end
      if (k == inject_at) begin
        start = 1'b1; a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
      end else if (k == inject_at + 1) begin
        start = 1'b0;
      end
      if (halt_len > 0 && k == halt_at) halt_sys = 1'b1;
      if (halt_len > 0 && k == halt_at + halt_len) halt_sys = 1'b0;
    end
    start = 1'b0; halt_sys = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'((exp[32] ? 1 : 17) + halt_len));
    check({tag, " result"}, got_res, exp[31:0]);
    check({tag, " div0"}, 32'(got_div0), 32'(exp[32]));
    check({tag, " stall_cycles"}, 32'(stalls), 32'(exp[32] ? 1 : 17));
    @(negedge clk);
    check({tag, " single_done"}, {30'h0, done, busy}, 32'h0);
    check({tag, " result_hold"}, result, exp[31:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; halt_sys = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset div0", 32'(div0), 32'd0);
    check("reset result", result, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    run_op("mul_3x5", 16'd3, 16'd5, 1'b0, 0, 0, 0);
`ifndef MULDIV_SIGNED_EN
    check("mul_3x5 const", result, 32'h0000000F);
`endif
    run_op("mul_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 0, 0, 0);
`ifndef MULDIV_SIGNED_EN
    check("mul_ffff const", result, 32'hFFFE0001);
`endif
    run_op("div_100_7", 16'd100, 16'd7, 1'b1, 0, 0, 0);
`ifndef MULDIV_SIGNED_EN
    check("div_100_7 const", result, 32'h0002000E);
`endif
    run_op("div_zero", 16'h1234, 16'h0, 1'b1, 0, 0, 0);
    check("div_zero const", result, 32'h1234FFFF);
    run_op("mul_zero", 16'h0, 16'hBEEF, 1'b0, 0, 0, 0);
    run_op("div_small", 16'd5, 16'd9, 1'b1, 0, 0, 0);

    run_op("restart_ignored", 16'd1234, 16'd56, 1'b0, 5, 0, 0);
    run_op("halt_mid_calc", 16'd50000, 16'd123, 1'b1, 0, 6, 5);

`ifdef MULDIV_SIGNED_EN
    run_op("sdiv_m7_2", 16'hFFF9, 16'd2, 1'b1, 0, 0, 0);
    check("sdiv_m7_2 const", result, 32'hFFFFFFFD);
    run_op("smul_m3_4", 16'hFFFD, 16'd4, 1'b0, 0, 0, 0);
    check("smul_m3_4 const", result, 32'hFFFFFFF4);
`endif

    // Abort at CALC iteration 8: everything clears immediately.
    @(negedge clk);
    a = 16'd777; b = 16'd3; op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort stall", 32'(stall), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort div0", 32'(div0), 32'd0);
    check("abort result", result, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    run_op("after_reset", 16'd321, 16'd10, 1'b1, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      logic [15:0] ra, rb;
      logic        rop;
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      rop = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), ra, rb, rop, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
